leaf_rho: RTL and testbench
===========================

// Module: leaf_rho
// PURPOSE
//   Parametrised history-combine stage for leaf token streams. Keeps a DEPTH-entry
//   ring of past accepted tokens and combines each new token with the one accepted
//   DEPTH beats earlier using a per-beat mode (XOR/ADD/SUB/PASS).
//   Sits between leaf producers and consumers. Valid/ready on both sides, registered output.
// PARAMETERS
//   WIDTH  32  token width in bits (>=1)
//   DEPTH  4   history depth in accepted beats (>=2; non-power-of-two supported)
// PORTS
//   clk        in   1           sole clock, rising edge
//   rst        in   1           asynchronous, active-high reset
//   flush      in   1           synchronous clear of history/pointer/fill count/output
//   mode       in   2           combine op, sampled with each accepted beat (mode_e)
//   in_valid   in   1           input token valid
//   in_ready   out  1           stage can accept a token this cycle
//   in_data    in   WIDTH       input token
//   out_valid  out  1           out_data/out_primed valid
//   out_ready  in   1           downstream accepts output this cycle
//   out_data   out  WIDTH       combined token
//   out_primed out  1           1 = history word used was a real token (ring was full)
// BEHAVIOUR
//   - Reset (async, rst=1): ptr=0, fill=0, all ring entries=0, out_valid=0, out_data=0,
//     out_primed=0. Outputs hold these values while rst is high.
//   - in_ready = !flush && (!out_valid || out_ready). Accept = in_valid && in_ready.
//   - On accept, with h = ring[ptr]:
//       XOR: out_data <= in_data ^ h     ADD: out_data <= in_data + h (mod 2^WIDTH)
//       SUB: out_data <= in_data - h (mod 2^WIDTH)   PASS: out_data <= h
//     out_primed <= (fill==DEPTH); ring[ptr] <= in_data; out_valid <= 1.
//     ptr <= (ptr==DEPTH-1) ? 0 : ptr+1; fill <= min(fill+1, DEPTH).
//   - Latency: 1 cycle, accept to out_valid. Full throughput (1 beat/cycle) while out_ready=1.
//   - Output held stable while out_valid && !out_ready. No ring/ptr change without accept.
//   - out_valid clears on (out_valid && out_ready && !accept).
//   - Accept and output-handshake in the same cycle: the new beat replaces the old one;
//     out_valid stays 1.
//   - flush=1: ring zeroed, ptr=0, fill=0, out_valid=0, out_primed=0, out_data=0.
//     Flush wins over every simultaneous event. A held output is discarded. No beat is
//     accepted that cycle (in_ready=0).
//   - Before the ring fills (fill<DEPTH), h is 0 from reset/flush: XOR/ADD/SUB pass
//     in_data unchanged, PASS emits 0, out_primed=0.
//   - mode is combinational-don't-care when no accept occurs. An illegal value is
//     impossible (2-bit enum fully decoded).
//   - Reset asserted mid-stream: in-flight output is lost. Stream restarts unprimed.
// STRUCTURE
//   - leaf_pkg: typedef enum logic [1:0] {MODE_XOR=2'd0, MODE_ADD=2'd1, MODE_SUB=2'd2,
//     MODE_PASS=2'd3} mode_e; combine function leaf_combine(mode_e, a, b).
//   - Sub-module leaf_ring_mem #(WIDTH,DEPTH): ring storage, ptr with wrap, fill counter,
//     clear input. Exposes rd_data=ring[ptr] and full=(fill==DEPTH).
//   - Top: handshake/output register + combine via leaf_pkg function.
// TESTING (WIDTH=32, DEPTH=4 unless noted)
//   1 XOR, out_ready=1: in 1,2,3,4,5,6 -> out 1,2,3,4 (primed=0); 4 (5^1), 4 (6^2) (primed=1).
//   2 Backpressure: beat 0xA accepted, out_ready=0 for 3 cycles -> in_ready=0,
//     out_data=0xA held; then beat 0xB follows with no loss or duplication.
//   3 ADD/SUB wrap: history 0xFFFFFFFF, in 0x2 ADD -> 0x00000001.
//     History 0x5, in 0x3 SUB -> 0xFFFFFFFE.
//   4 PASS with DEPTH=3: in 7,8,9,10,11 -> out 0,0,0,7,8. Checks non-pow2 pointer wrap.
//   5 Flush with in_valid=1 and held out_valid: beat dropped, out_valid=0 next cycle.
//     Next beat 0x9 in XOR -> out 0x9, primed=0.
//   6 rst pulse mid-stream (asynchronous, between edges): outputs zero immediately.
//     Sequence 1 replayed after release gives identical results.

Source files
------------

// File: rtl/leaf_pkg.sv
// Shared types and the combine operator for the leaf history stage.
package leaf_pkg;

    typedef enum logic [1:0] {
        MODE_XOR  = 2'd0,
        MODE_ADD  = 2'd1,
        MODE_SUB  = 2'd2,
        MODE_PASS = 2'd3
    } mode_e;

    // Widest token the combine function handles; callers zero-extend and slice.
    localparam int LEAF_MAX_W = 64;

    // Low bits of add/sub depend only on low operand bits, so slicing the
    // result back to the caller width gives the correct modular value.
    function automatic logic [LEAF_MAX_W-1:0] leaf_combine(
        input mode_e                 mode,
        input logic [LEAF_MAX_W-1:0] a,
        input logic [LEAF_MAX_W-1:0] h
    );
        logic [LEAF_MAX_W-1:0] result;
        result = h;
        case (mode)
            MODE_XOR:  result = a ^ h;
            MODE_ADD:  result = a + h;
            MODE_SUB:  result = a - h;
            MODE_PASS: result = h;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/leaf_ring_mem.sv
// DEPTH-entry history ring: write pointer with wrap, saturating fill count.
module leaf_ring_mem
    import leaf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

    logic [WIDTH-1:0]  ring_bus [DEPTH];
    logic [PTR_W-1:0]  ptr_reg;
    logic [FILL_W-1:0] fill_reg;

    // Each entry is its own register so the whole ring can be cleared at once.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (clear) begin
                    entry_reg <= '0;
                end else if (wr_en && (ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= wr_data;
                end
            end
            assign ring_bus[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg  <= '0;
            fill_reg <= '0;
        end else if (clear) begin
            ptr_reg  <= '0;
            fill_reg <= '0;
        end else if (wr_en) begin
            ptr_reg <= (ptr_reg == PTR_LAST) ? '0 : ptr_reg + 1'b1;
            if (fill_reg != FILL_MAX) begin
                fill_reg <= fill_reg + 1'b1;
            end
        end
    end

    assign rd_data = ring_bus[ptr_reg];
    assign full    = (fill_reg == FILL_MAX);

endmodule

// File: rtl/leaf_rho.sv
// History-combine stage: merges each accepted token with the one accepted
// DEPTH beats earlier, behind a single registered valid/ready output slot.
module leaf_rho
    import leaf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_primed
);

    logic                  accept;
    logic [WIDTH-1:0]      hist_data;
    logic                  hist_full;
    logic [LEAF_MAX_W-1:0] combined;
    logic [WIDTH-1:0]      out_data_next;

    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_primed_reg;

    assign in_ready = !flush && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;

    leaf_ring_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .clear   (flush),
        .wr_en   (accept),
        .wr_data (in_data),
        .rd_data (hist_data),
        .full    (hist_full)
    );

    assign combined      = leaf_combine(mode_e'(mode), LEAF_MAX_W'(in_data),
                                        LEAF_MAX_W'(hist_data));
    assign out_data_next = combined[WIDTH-1:0];

    generate
        if (WIDTH < LEAF_MAX_W) begin : g_hi
            logic hi_unused;
            assign hi_unused = ^combined[LEAF_MAX_W-1:WIDTH];
        end
    endgenerate

    // Flush beats everything; a consumed slot is refilled in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_primed_reg <= 1'b0;
        end else if (flush) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_primed_reg <= 1'b0;
        end else if (accept) begin
            out_valid_reg  <= 1'b1;
            out_data_reg   <= out_data_next;
            out_primed_reg <= hist_full;
        end else if (out_ready) begin
            out_valid_reg  <= 1'b0;
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_primed = out_primed_reg;

endmodule

// File: tb/tb_leaf_rho.sv
// Bench for leaf_rho: DEPTH=4 and DEPTH=3 instances, table-driven beats with a scoreboard.
module tb_leaf_rho;
    import leaf_pkg::*;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] din;
        logic [31:0] dout;
        logic        primed;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        primed;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [1:0]       flush;
    logic [1:0][1:0]  mode;
    logic [1:0]       in_valid;
    logic [1:0]       in_ready;
    logic [1:0][31:0] in_data;
    logic [1:0]       out_valid;
    logic [1:0]       out_ready;
    logic [1:0][31:0] out_data;
    logic [1:0]       out_primed;

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t q0[$];
    exp_t q1[$];

    vec_t seq1[6];
    vec_t seq3[6];
    vec_t seq4[5];

    leaf_rho #(.WIDTH(32), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush[0]), .mode(mode[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_primed(out_primed[0])
    );

    leaf_rho #(.WIDTH(32), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .flush(flush[1]), .mode(mode[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_primed(out_primed[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    task automatic mon(input int d);
        exp_t e;
        if (out_valid[d] && out_ready[d]) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_out dut%0d: got %h expected none", d, out_data[d]);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("out_data dut%0d", d), out_data[d], e.data);
                chk($sformatf("out_primed dut%0d", d), 32'(out_primed[d]), 32'(e.primed));
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0);
            mon(1);
        end
    end

    // Drive one beat; expectation is queued at the cycle it is known to be accepted.
    task automatic send(input int d, input logic [1:0] m, input logic [31:0] din,
                        input logic [31:0] dout, input logic p);
        bit   ok = 0;
        exp_t e;
        in_valid[d] = 1'b1;
        mode[d]     = m;
        in_data[d]  = din;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready[d]) begin
                e.data   = dout;
                e.primed = p;
                if (d == 0) q0.push_back(e);
                else        q1.push_back(e);
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_miss++;
            $display("FAIL send_timeout dut%0d: in_ready got 0 expected 1", d);
        end
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic drain();
        int left;
        for (int i = 0; i < 30; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(negedge clk);
        end
        left = q0.size() + q1.size();
        chk("drain_pending", 32'(left), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_flush(input int d);
        flush[d] = 1'b1;
        @(posedge clk); #1;
        flush[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 6; i++) begin
            seq1[i].mode   = MODE_XOR;
            seq1[i].din    = 32'(i + 1);
            seq1[i].dout   = (i < 4) ? 32'(i + 1) : 32'd4;
            seq1[i].primed = (i >= 4);
        end
        seq3[0] = '{MODE_XOR, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        seq3[1] = '{MODE_XOR, 32'h5,         32'h5,         1'b0};
        seq3[2] = '{MODE_XOR, 32'h0,         32'h0,         1'b0};
        seq3[3] = '{MODE_XOR, 32'h0,         32'h0,         1'b0};
        seq3[4] = '{MODE_ADD, 32'h2,         32'h1,         1'b1};
        seq3[5] = '{MODE_SUB, 32'h3,         32'hFFFF_FFFE, 1'b1};
        for (int i = 0; i < 5; i++) begin
            seq4[i].mode   = MODE_PASS;
            seq4[i].din    = 32'(i + 7);
            seq4[i].dout   = (i < 3) ? 32'd0 : 32'(i + 4);
            seq4[i].primed = (i >= 3);
        end

        rst = 1'b1; flush = '0; mode = '0; in_valid = '0; in_data = '0; out_ready = '0;
        @(negedge clk);
        chk("reset out_valid", 32'(out_valid[0]), 32'd0);
        chk("reset out_data", out_data[0], 32'd0);
        chk("reset out_primed", 32'(out_primed[0]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 2'b11;
        #1;
        chk("idle in_ready", 32'(in_ready[0]), 32'd1);

        // XOR history, full throughput
        for (int i = 0; i < 6; i++) send(0, seq1[i].mode, seq1[i].din, seq1[i].dout, seq1[i].primed);
        drain();

        // Backpressure holds output and blocks input
        do_flush(0);
        out_ready[0] = 1'b0;
        send(0, MODE_XOR, 32'hA, 32'hA, 1'b0);
        in_valid[0] = 1'b1; in_data[0] = 32'hB; mode[0] = MODE_XOR;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp in_ready", 32'(in_ready[0]), 32'd0);
            chk("bp out_valid", 32'(out_valid[0]), 32'd1);
            chk("bp hold", out_data[0], 32'hA);
        end
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        send(0, MODE_XOR, 32'hB, 32'hB, 1'b0);
        drain();

        // ADD/SUB wrap-around
        do_flush(0);
        for (int i = 0; i < 6; i++) send(0, seq3[i].mode, seq3[i].din, seq3[i].dout, seq3[i].primed);
        drain();

        // Flush against an incoming beat and a held output
        out_ready[0] = 1'b0;
        in_valid[0] = 1'b1; in_data[0] = 32'h77; mode[0] = MODE_XOR;
        @(posedge clk); #1;
        in_data[0] = 32'h88;
        flush[0] = 1'b1;
        @(negedge clk);
        chk("flush in_ready", 32'(in_ready[0]), 32'd0);
        chk("pre-flush out_valid", 32'(out_valid[0]), 32'd1);
        @(posedge clk); #1;
        flush[0] = 1'b0; in_valid[0] = 1'b0;
        chk("flush out_valid", 32'(out_valid[0]), 32'd0);
        chk("flush out_data", out_data[0], 32'd0);
        chk("flush out_primed", 32'(out_primed[0]), 32'd0);
        out_ready[0] = 1'b1;
        send(0, MODE_XOR, 32'h9, 32'h9, 1'b0);
        send(0, MODE_PASS, 32'h1, 32'h0, 1'b0);
        drain();

        // PASS on a non-power-of-two ring
        for (int i = 0; i < 5; i++) send(1, seq4[i].mode, seq4[i].din, seq4[i].dout, seq4[i].primed);
        drain();

        // Asynchronous reset mid-stream, then replay
        for (int i = 0; i < 3; i++) send(0, seq1[i].mode, seq1[i].din, seq1[i].dout, seq1[i].primed);
        #1 rst = 1'b1;
        #1;
        chk("async rst out_valid", 32'(out_valid[0]), 32'd0);
        chk("async rst out_data", out_data[0], 32'd0);
        chk("async rst out_primed", 32'(out_primed[0]), 32'd0);
        q0.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) send(0, seq1[i].mode, seq1[i].din, seq1[i].dout, seq1[i].primed);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
